// File: rtl/deadtime_pkg.sv
// Shared types and defaults for the complementary gate-drive dead-time generator.
package deadtime_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;
    localparam int DT_MIN_DEFAULT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LS_ON   = 3'd1,
        ST_DEAD_LH = 3'd2,
        ST_HS_ON   = 3'd3,
        ST_DEAD_HL = 3'd4,
        ST_FAULT   = 3'd5
    } dt_state_e;

    function automatic logic is_dead(input dt_state_e s);
        return (s == ST_DEAD_LH) || (s == ST_DEAD_HL);
    endfunction

endpackage

// File: rtl/deadtime_generator_if.sv
// Command/status bundle between the PWM source and the dead-time generator.
interface deadtime_generator_if
    import deadtime_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) ();

    logic                en;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_cycles;
    logic                fault_in;
    logic                hs_out;
    logic                ls_out;
    logic                busy;
    logic                fault_out;

    modport master (
        output en, pwm_in, dead_cycles, fault_in,
        input  hs_out, ls_out, busy, fault_out
    );

    modport slave (
        input  en, pwm_in, dead_cycles, fault_in,
        output hs_out, ls_out, busy, fault_out
    );

endinterface

// File: rtl/dt_counter.sv
// Loadable dead-interval down-counter; the load value is clamped to at least DT_MIN.
module dt_counter
    import deadtime_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT,
    parameter int DT_MIN   = DT_MIN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] load_val,
    input  logic                run,
    output logic                zero
);

    localparam logic [DT_WIDTH-1:0] MIN_VAL = DT_WIDTH'(DT_MIN);
    localparam logic [DT_WIDTH-1:0] ONE     = DT_WIDTH'(1);

    logic [DT_WIDTH-1:0] count_reg;
    logic [DT_WIDTH-1:0] count_next;
    logic [DT_WIDTH-1:0] load_clamped;

    always_comb begin
        load_clamped = (load_val < MIN_VAL) ? MIN_VAL : load_val;
        count_next   = count_reg;
        if (load) begin
            count_next = load_clamped;
        end else if (run && (count_reg != '0)) begin
            count_next = count_reg - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Asserted on the cycle whose decrement lands on 0, so the FSM leaves the
    // dead state on that same edge and the gap is exactly the loaded count.
    assign zero = (count_reg <= ONE);

endmodule

// File: rtl/deadtime_generator.sv
// Complementary high/low gate drive with programmable dead time and fault shutdown.
// Define DEADTIME_FAULT_LATCH_EN to make the FAULT state sticky until rst.
module deadtime_generator
    import deadtime_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT,
    parameter int DT_MIN   = DT_MIN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    deadtime_generator_if.slave  bus
);

    dt_state_e state_reg;
    dt_state_e state_next;

    logic hs_reg;
    logic hs_next;
    logic ls_reg;
    logic ls_next;
    logic fault_reg;
    logic fault_next;
    logic dead_active;

    logic cnt_load;
    logic cnt_run;
    logic cnt_zero;

    // Gates are registered from the current state: a single state can never
    // assert both, and an async reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            hs_reg    <= 1'b0;
            ls_reg    <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hs_reg    <= hs_next;
            ls_reg    <= ls_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_FAULT) begin
`ifdef DEADTIME_FAULT_LATCH_EN
            state_next = ST_FAULT;
`else
            state_next = bus.fault_in ? ST_FAULT : ST_IDLE;
`endif
        end else if (bus.fault_in) begin
            state_next = ST_FAULT;
        end else if (!bus.en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    state_next = bus.pwm_in ? ST_DEAD_LH : ST_DEAD_HL;
                ST_LS_ON:   if (bus.pwm_in)  state_next = ST_DEAD_LH;
                ST_HS_ON:   if (!bus.pwm_in) state_next = ST_DEAD_HL;
                // Expiry wins over a late reversal; the reversal is then taken from the ON state.
                ST_DEAD_LH: begin
                    if (cnt_zero)         state_next = ST_HS_ON;
                    else if (!bus.pwm_in) state_next = ST_LS_ON;
                end
                ST_DEAD_HL: begin
                    if (cnt_zero)         state_next = ST_LS_ON;
                    else if (bus.pwm_in)  state_next = ST_HS_ON;
                end
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hs_next     = (state_reg == ST_HS_ON);
        ls_next     = (state_reg == ST_LS_ON);
        fault_next  = (state_reg == ST_FAULT);
        dead_active = is_dead(state_reg);
    end

    // Reload only on entry so dead_cycles changes mid-interval have no effect.
    assign cnt_load = is_dead(state_next) && (state_next != state_reg);
    assign cnt_run  = is_dead(state_reg);

    dt_counter #(
        .DT_WIDTH (DT_WIDTH),
        .DT_MIN   (DT_MIN)
    ) u_dt_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (bus.dead_cycles),
        .run      (cnt_run),
        .zero     (cnt_zero)
    );

    assign bus.hs_out    = hs_reg;
    assign bus.ls_out    = ls_reg;
    assign bus.busy      = dead_active;
    assign bus.fault_out = fault_reg;

endmodule

// File: tb/tb_deadtime_generator.sv
// Scenario bench for deadtime_generator: per-cycle expected {hs, ls, busy, fault_out} via a scoreboard queue.
module tb_deadtime_generator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [3:0] exp_q[$];

    deadtime_generator_if #(.DT_WIDTH(W)) bus ();

    deadtime_generator #(.DT_WIDTH(W), .DT_MIN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] observe();
        return {bus.hs_out, bus.ls_out, bus.busy, bus.fault_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic pwm, input logic fault, input logic [W-1:0] dead);
        bus.en          = en;
        bus.pwm_in      = pwm;
        bus.fault_in    = fault;
        bus.dead_cycles = dead;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic settle(input logic pwm, input logic [W-1:0] dead);
        drive(1'b1, pwm, 1'b0, dead);
        repeat (6) tick();
    endtask

    task automatic test_reset();
        logic [3:0] got, want;
        drive(1'b1, 1'b1, 1'b0, 8'd5);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'b0000);
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
        rst = 1'b0;
        exp_q.push_back(4'b0010);
        tick();
        got = observe(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_release hs/ls/busy/flt got %b want %b", got, want);
        end
    endtask

    task automatic test_startup();
        logic [3:0] got, want;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'd4);
            exp_q.push_back({1'b0, k >= 5, k <= 3, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL startup k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_lh_transition();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd1);
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd10);
            exp_q.push_back({k >= 11, k == 0, k <= 9, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL lh_dead10 k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_min_dead();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd0);
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, k < 6, 1'b0, 8'd0);
            exp_q.push_back({(k >= 2) && (k < 7), (k < 1) || (k >= 8), (k == 0) || (k == 6), 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL min_dead k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_pulse();
        logic [3:0] got, want;
        do_reset();
        settle(1'b1, 8'd1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, k >= 3, 1'b0, 8'd8);
            exp_q.push_back({!((k >= 1) && (k <= 3)), 1'b0, k <= 2, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL short_pulse k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_dead_change();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd2);
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 1'b0, (k == 0) ? 8'd5 : 8'd0);
            exp_q.push_back({k >= 6, k == 0, k <= 4, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL dead_change k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_edge_at_zero();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd3);
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, k < 3, 1'b0, 8'd3);
            exp_q.push_back({k == 4, (k == 0) || (k >= 8), (k <= 2) || ((k >= 4) && (k <= 6)), 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL edge_at_zero k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd2);
        for (int k = 0; k < 10; k++) begin
            drive(k >= 4, 1'b0, 1'b0, 8'd2);
            exp_q.push_back({1'b0, (k == 0) || (k >= 7), (k == 4) || (k == 5), 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL en_drop k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_fault();
        logic [3:0] got, want;
        logic en_k, hs_w, busy_w, fo_w;
        do_reset();
        settle(1'b1, 8'd3);
        for (int k = 0; k < 10; k++) begin
`ifdef DEADTIME_FAULT_LATCH_EN
            en_k   = (k < 5);
            hs_w   = (k == 0);
            busy_w = 1'b0;
            fo_w   = (k >= 1);
`else
            en_k   = 1'b1;
            hs_w   = (k == 0) || (k >= 6);
            busy_w = (k >= 2) && (k <= 4);
            fo_w   = (k == 1);
`endif
            drive(en_k, 1'b1, k == 0, 8'd3);
            exp_q.push_back({hs_w, 1'b0, busy_w, fo_w});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL fault_pulse k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
        #3 rst = 1'b1;
        exp_q.push_back(4'b0000);
        #1;
        got = observe(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL fault_rst_clear hs/ls/busy/flt got %b want %b", got, want);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [3:0] got, want;
        do_reset();
        settle(1'b0, 8'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd6);
            exp_q.push_back({1'b0, k == 0, 1'b1, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rst_mid_pre k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
        #3 rst = 1'b1;
        exp_q.push_back(4'b0000);
        #1;
        got = observe(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid_dead hs/ls/busy/flt got %b want %b", got, want);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd6);
            exp_q.push_back({k >= 7, 1'b0, k <= 5, 1'b0});
            tick();
            got = observe(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rst_mid_post k=%0d hs/ls/busy/flt got %b want %b", k, got, want);
            end
        end
        #3 rst = 1'b1;
        exp_q.push_back(4'b0000);
        #1;
        got = observe(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid_hs_on hs/ls/busy/flt got %b want %b", got, want);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        test_reset();
        test_startup();
        test_lh_transition();
        test_min_dead();
        test_pulse();
        test_dead_change();
        test_edge_at_zero();
        test_en_drop();
        test_fault();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
